// File: rtl/song_reader_if.sv
// Song sequencer bundle: player controls, ROM bus, note_player load.
// master = song_reader side, slave = environment side.
interface song_reader_if #(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5
);
  logic                          play;
  logic [SONG_BITS-1:0]          song;
  logic                          note_done;
  logic [SONG_BITS+IDX_BITS-1:0] rom_addr;
  logic [11:0]                   rom_data;
  logic [5:0]                    note_to_load;
  logic [5:0]                    duration_to_load;
  logic                          load_new_note;
  logic                          song_done;

  modport master (
    input  play, song, note_done, rom_data,
    output rom_addr, note_to_load, duration_to_load,
    output load_new_note, song_done
  );

  modport slave (
    output play, song, note_done, rom_data,
    input  rom_addr, note_to_load, duration_to_load,
    input  load_new_note, song_done
  );
endinterface

// File: rtl/song_reader.sv
// song_reader: walks a song in a sync ROM and feeds note_player.
// Ports: clk, reset (async high), bus (song_reader_if.master):
//   play/song/note_done in, rom_addr/rom_data ROM bus,
//   note_to_load/duration_to_load/load_new_note out, song_done out.
// Option: define SONG_REPEAT_EN to loop the song at its end.
module song_reader #(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5
) (
  input  logic           clk,
  input  logic           reset,
  song_reader_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [IDX_BITS-1:0] LP_IDX_MAX = '1;

  state_t                r_state;
  logic [IDX_BITS-1:0]   r_idx;
  logic [SONG_BITS-1:0]  r_song_q;
  logic [5:0]            r_note;
  logic [5:0]            r_dur;
  logic                  r_load;
  logic                  r_done;

  logic w_pause;
  logic w_song_chg;
  logic w_end;

  assign w_pause    = !bus.play;
  assign w_song_chg = (bus.song != r_song_q);
  assign w_end      = (bus.rom_data[5:0] == 6'd0);

  // Address is a pure function of registered state.
  assign bus.rom_addr         = {r_song_q, r_idx};
  assign bus.note_to_load     = r_note;
  assign bus.duration_to_load = r_dur;
  assign bus.load_new_note    = r_load;
  assign bus.song_done        = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_song_q <= '0;
      r_note   <= '0;
      r_dur    <= '0;
      r_load   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // idx kept: resume refetches the interrupted note
          if (bus.play) begin
            r_song_q <= bus.song;
            r_state  <= S_FETCH;
          end
        end
        S_DONE: begin
`ifdef SONG_REPEAT_EN
          r_done   <= 1'b0;
          r_idx    <= '0;
          r_song_q <= bus.song;
          r_state  <= bus.play ? S_FETCH : S_IDLE;
`else
          if (w_pause || w_song_chg) begin
            r_done  <= 1'b0;
            r_idx   <= '0;
            r_state <= S_IDLE;
          end
`endif
        end
        default: begin
          // pause beats song change beats note_done
          if (w_pause) begin
            r_state <= S_IDLE;
          end else if (w_song_chg) begin
            r_idx    <= '0;
            r_song_q <= bus.song;
            r_state  <= S_FETCH;
          end else begin
            case (r_state)
              S_FETCH: r_state <= S_DECODE;
              S_DECODE: begin
                if (w_end) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
                end else begin
                  r_note  <= bus.rom_data[11:6];
                  r_dur   <= bus.rom_data[5:0];
                  r_load  <= 1'b1;
                  r_state <= S_LOAD;
                end
              end
              S_LOAD: r_state <= S_WAIT;
              S_WAIT: begin
                if (bus.note_done) begin
                  if (r_idx == LP_IDX_MAX) begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                  end else begin
                    r_idx   <= r_idx + 1'b1;
                    r_state <= S_FETCH;
                  end
                end
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: directed stimulus, queue scoreboard on load_new_note.
// Sync ROM model answers rom_addr one cycle later.
module tb_song_reader;

  logic clk = 1'b0;
  logic reset = 1'b1;

  song_reader_if #(.SONG_BITS(2), .IDX_BITS(5)) bus ();

  song_reader #(.SONG_BITS(2), .IDX_BITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [128];

  always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

  int errors = 0;
  int checks = 0;

  // {rom_addr, note, duration} expected at each load pulse
  logic [18:0] exp_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] ent(input int a, input int n, input int d);
    return {7'(a), 6'(n), 6'(d)};
  endfunction

  always @(negedge clk) begin
    if (bus.load_new_note) begin
      logic [18:0] got;
      got = {bus.rom_addr, bus.note_to_load, bus.duration_to_load};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_load act=0x%0h exp=none", got);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL load act=0x%0h exp=0x%0h", got, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_load(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      tick(1);
      n++;
      if (bus.load_new_note) seen = 1'b1;
    end
    if (!seen) chk("load_timeout", 0, 1);
  endtask

  task automatic wait_done(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      tick(1);
      n++;
      if (bus.song_done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic pulse_nd;
    bus.note_done = 1'b1;
    tick(1);
    bus.note_done = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[7'h20] = {6'd20, 6'd4};
    mem[7'h21] = {6'd25, 6'd2};
    mem[7'h22] = '0;
    mem[7'h40] = {6'd30, 6'd5};
    mem[7'h00] = {6'd10, 6'd3};
    for (int i = 0; i < 32; i++)
      mem[7'h60 + i] = {6'(i + 1), 6'(i % 7 + 1)};
    bus.play = 1'b0;
    bus.song = 2'd0;
    bus.note_done = 1'b0;

    #1;
    chk("rst_outs", int'({bus.rom_addr, bus.note_to_load,
        bus.duration_to_load, bus.load_new_note, bus.song_done}), 0);
    tick(2);
    reset = 1'b0;
    tick(1);

    // song 1 first note, 3-cycle latency
    bus.song = 2'd1;
    exp_q.push_back(ent('h20, 20, 4));
    bus.play = 1'b1;
    wait_load(n);
    chk("latency", n, 3);
    tick(1);
    exp_q.push_back(ent('h21, 25, 2));
    pulse_nd();
    wait_load(n);
    chk("addr_idx1", int'(bus.rom_addr), 'h21);

    // pause in WAIT on idx 1, resume refetches idx 1
    tick(1);
    bus.play = 1'b0;
    tick(1);
    tick(2);
    chk("pause_quiet", int'({bus.load_new_note, bus.song_done}), 0);
    exp_q.push_back(ent('h21, 25, 2));
    bus.play = 1'b1;
    wait_load(n);
    chk("resume_lat", n, 3);

    // end marker
    tick(1);
`ifdef SONG_REPEAT_EN
    exp_q.push_back(ent('h20, 20, 4));
`endif
    pulse_nd();
    wait_done(n);
    chk("done_lat", n, 2);
`ifdef SONG_REPEAT_EN
    tick(1);
    chk("done_pulse", int'(bus.song_done), 0);
    wait_load(n);
`else
    tick(4);
    chk("done_hold", int'(bus.song_done), 1);
    chk("done_addr", int'(bus.rom_addr), 'h22);
`endif
    bus.play = 1'b0;
    tick(2);
    chk("done_exit", int'(bus.song_done), 0);

    // song change 1 -> 2 in WAIT
    exp_q.push_back(ent('h20, 20, 4));
    bus.play = 1'b1;
    wait_load(n);
    tick(1);
    exp_q.push_back(ent('h40, 30, 5));
    bus.song = 2'd2;
    tick(1);
    chk("chg_addr", int'(bus.rom_addr), 'h40);
    wait_load(n);
    chk("chg_nodone", int'(bus.song_done), 0);

    // song change wins over note_done
    tick(1);
    exp_q.push_back(ent('h20, 20, 4));
    bus.song = 2'd1;
    pulse_nd();
    chk("chg_prio", int'(bus.rom_addr), 'h20);
    wait_load(n);

    // pause wins over note_done
    tick(1);
    bus.play = 1'b0;
    pulse_nd();
    tick(1);
    chk("pause_prio", int'(bus.rom_addr), 'h20);
    exp_q.push_back(ent('h20, 20, 4));
    bus.play = 1'b1;
    wait_load(n);

    // full 32-entry song 3, no end marker
    tick(1);
    exp_q.push_back(ent('h60, 1, 1));
    bus.song = 2'd3;
    for (int i = 0; i < 32; i++) begin
      wait_load(n);
      tick(1);
      if (i < 31)
        exp_q.push_back(ent('h60 + i + 1, i + 2, (i + 1) % 7 + 1));
`ifdef SONG_REPEAT_EN
      else
        exp_q.push_back(ent('h60, 1, 1));
`endif
      pulse_nd();
    end
    chk("full_done", int'(bus.song_done), 1);
    chk("full_nowrap", int'(bus.rom_addr), 'h7f);
`ifdef SONG_REPEAT_EN
    tick(1);
    chk("full_pulse", int'(bus.song_done), 0);
    wait_load(n);
`else
    tick(3);
    chk("full_hold", int'(bus.song_done), 1);
    chk("full_hold_addr", int'(bus.rom_addr), 'h7f);
`endif
    bus.play = 1'b0;
    tick(2);

    // reset asserted during LOAD
    bus.song = 2'd0;
    bus.play = 1'b1;
    wait_load(n);
    reset = 1'b1;
    #1;
    chk("rst_load", int'(bus.load_new_note), 0);
    chk("rst_note", int'({bus.note_to_load, bus.duration_to_load}), 0);
    chk("rst_addr_done", int'({bus.rom_addr, bus.song_done}), 0);
    exp_q.push_back(ent('h00, 10, 3));
    tick(2);
    reset = 1'b0;
    wait_load(n);
    chk("post_rst_lat", n, 3);
    chk("post_rst_addr", int'(bus.rom_addr), 0);

    tick(2);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
